// File: rtl/shadow_register_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shadow_register_bank: double-buffered register bank, byte-strobed shadow |
// | writes, sequential shadow-to-active commit, registered read port.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shadow_register_bank #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 4,
  parameter int                    ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [DATA_WIDTH/8-1:0]       wr_strb,
  input  logic                          commit,
  output logic                          commit_done,
  input  logic                          rd_en,
  input  logic                          rd_sel,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          err,
  input  logic                          err_clear,
  output logic [DEPTH*DATA_WIDTH-1:0]   register_out
);

  localparam int                    c_strb_width = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   c_depth_ext  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_idx   = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_t;

  state_t                        r_state;
  logic [ADDR_WIDTH-1:0]         r_cnt;
  logic                          r_commit_done;
  logic                          r_rd_valid;
  logic [DATA_WIDTH-1:0]         r_rd_data;
  logic                          r_err;

  logic                          w_wr_fire;
  logic                          w_wr_in_range;
  logic                          w_rd_in_range;
  logic                          w_err_set;
  logic                          w_copying;
  logic [DATA_WIDTH-1:0]         w_rd_word;
  logic [DEPTH*DATA_WIDTH-1:0]   w_shadow_flat;

  assign wr_ready      = (r_state == ST_IDLE);
  assign w_wr_fire     = wr_valid && wr_ready;
  assign w_copying     = (r_state == ST_COPY);
  assign w_wr_in_range = ({1'b0, wr_addr} < c_depth_ext);
  assign w_rd_in_range = ({1'b0, rd_addr} < c_depth_ext);
  assign w_err_set     = (w_wr_fire && !w_wr_in_range) || (rd_en && !w_rd_in_range);

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] r_active;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= RESET_VALUE;
      end else if (w_wr_fire && (wr_addr == ADDR_WIDTH'(k))) begin
        for (int b = 0; b < c_strb_width; b++) begin
          if (wr_strb[b]) r_shadow[b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_active <= RESET_VALUE;
      end else if (w_copying && (r_cnt == ADDR_WIDTH'(k))) begin
        r_active <= r_shadow;
      end
    end

    assign w_shadow_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_shadow;
    assign register_out[k*DATA_WIDTH +: DATA_WIDTH]  = r_active;
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr == ADDR_WIDTH'(k)) begin
        w_rd_word = rd_sel ? w_shadow_flat[k*DATA_WIDTH +: DATA_WIDTH]
                           : register_out[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_commit_done <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_commit_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (commit) begin
            r_state <= ST_COPY;
            r_cnt   <= '0;
          end
        end
        ST_COPY: begin
          if (r_cnt == c_last_idx) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_commit_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase

      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_word;

      // A new error event outranks a simultaneous clear.
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clear) r_err <= 1'b0;
    end
  end

  assign commit_done = r_commit_done;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shadow_register_bank.sv
`default_nettype none
// Bench for shadow_register_bank: DEPTH=4 and DEPTH=3 banks share stimulus and
// are checked each cycle against a timeline model; a 16-bit bank gets directed checks.
module tb_shadow_register_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wr_valid, commit, rd_en, rd_sel, err_clear;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [0:0] wr_strb;

  logic        a_wr_ready, a_commit_done, a_rd_valid, a_err;
  logic [7:0]  a_rd_data;
  logic [31:0] a_reg;
  logic        c_wr_ready, c_commit_done, c_rd_valid, c_err;
  logic [7:0]  c_rd_data;
  logic [23:0] c_reg;

  logic        b_wr_valid, b_commit, b_rd_en, b_rd_sel, b_err_clear;
  logic [1:0]  b_wr_addr, b_rd_addr, b_wr_strb;
  logic [15:0] b_wr_data;
  logic        b_wr_ready, b_commit_done, b_rd_valid, b_err;
  logic [15:0] b_rd_data;
  logic [63:0] b_reg;

  shadow_register_bank #(.DATA_WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .commit(commit),
    .commit_done(a_commit_done), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .err(a_err), .err_clear(err_clear),
    .register_out(a_reg));

  shadow_register_bank #(.DATA_WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(c_wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .commit(commit),
    .commit_done(c_commit_done), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_valid(c_rd_valid), .rd_data(c_rd_data), .err(c_err), .err_clear(err_clear),
    .register_out(c_reg));

  shadow_register_bank #(.DATA_WIDTH(16), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_strb(b_wr_strb), .commit(b_commit),
    .commit_done(b_commit_done), .rd_en(b_rd_en), .rd_sel(b_rd_sel), .rd_addr(b_rd_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .err(b_err), .err_clear(b_err_clear),
    .register_out(b_reg));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bank b copies entry k on edge c0+1+k after a commit accepted on edge c0.
  logic [7:0] m_sh [2][4];
  logic [7:0] m_ac [2][4];
  logic [7:0] o_sh [4];
  logic [7:0] o_ac [4];
  int         dep [2] = '{4, 3};
  int         c0 [2];
  int         n = 0;
  int         kc;
  bit         cp, rdy, eset;
  logic       m_rv [2], m_done [2], m_err [2];
  logic [7:0] m_rd [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 4; k++) begin
          m_sh[b][k] = 8'hA5;
          m_ac[b][k] = 8'hA5;
        end
        m_rv[b] = 1'b0; m_rd[b] = 8'h00; m_done[b] = 1'b0; m_err[b] = 1'b0;
        c0[b] = -100;
      end
    end else begin
      n++;
      for (int b = 0; b < 2; b++) begin
        cp   = (n > c0[b]) && (n <= c0[b] + dep[b]);
        rdy  = !cp;
        eset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          o_sh[k] = m_sh[b][k];
          o_ac[k] = m_ac[b][k];
        end
        m_rv[b] = rd_en;
        if (rd_en) begin
          if (int'(rd_addr) < dep[b]) m_rd[b] = rd_sel ? o_sh[rd_addr] : o_ac[rd_addr];
          else begin m_rd[b] = 8'h00; eset = 1'b1; end
        end
        if (wr_valid && rdy) begin
          if (int'(wr_addr) < dep[b]) begin
            if (wr_strb[0]) m_sh[b][wr_addr] = wr_data;
          end else eset = 1'b1;
        end
        m_done[b] = 1'b0;
        if (cp) begin
          kc = n - c0[b] - 1;
          m_ac[b][kc] = m_sh[b][kc];
          m_done[b] = (kc == dep[b] - 1);
        end
        if (commit && rdy) c0[b] = n;
        m_err[b] = eset ? 1'b1 : (err_clear ? 1'b0 : m_err[b]);
      end
    end
  end

  function automatic logic exp_ready(input int b);
    return !((n + 1 > c0[b]) && (n + 1 <= c0[b] + dep[b]));
  endfunction

  always @(posedge clk) begin
    #1;
    chk("a_wr_ready", a_wr_ready, exp_ready(0));
    chk("a_commit_done", a_commit_done, m_done[0]);
    chk("a_rd_valid", a_rd_valid, m_rv[0]);
    chk("a_rd_data", a_rd_data, m_rd[0]);
    chk("a_err", a_err, m_err[0]);
    chk("a_register_out", a_reg, {m_ac[0][3], m_ac[0][2], m_ac[0][1], m_ac[0][0]});
    chk("c_wr_ready", c_wr_ready, exp_ready(1));
    chk("c_commit_done", c_commit_done, m_done[1]);
    chk("c_rd_valid", c_rd_valid, m_rv[1]);
    chk("c_rd_data", c_rd_data, m_rd[1]);
    chk("c_err", c_err, m_err[1]);
    chk("c_register_out", c_reg, {m_ac[1][2], m_ac[1][1], m_ac[1][0]});
  end

  int cnt_busy = 0, cnt_done_a = 0, cnt_done_c = 0;
  always @(posedge clk) begin
    #1;
    if (!a_wr_ready)   cnt_busy++;
    if (a_commit_done) cnt_done_a++;
    if (c_commit_done) cnt_done_c++;
  end

  task automatic drv(input logic v, input logic [1:0] a, input logic [7:0] d, input logic s,
                     input logic cm, input logic re, input logic rs, input logic [1:0] ra,
                     input logic ec);
    @(negedge clk);
    wr_valid = v; wr_addr = a; wr_data = d; wr_strb = s; commit = cm;
    rd_en = re; rd_sel = rs; rd_addr = ra; err_clear = ec;
  endtask

  task automatic idle();
    drv(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_cnt();
    cnt_busy = 0; cnt_done_a = 0; cnt_done_c = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    wr_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0; commit = 0;
    rd_en = 0; rd_sel = 0; rd_addr = 0; err_clear = 0;
    b_wr_valid = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_strb = 0; b_commit = 0;
    b_rd_en = 0; b_rd_sel = 0; b_rd_addr = 0; b_err_clear = 0;
    #2 rst_n = 1'b0;
    settle();
    chk("reset_register_out", a_reg, 32'hA5A5A5A5);
    chk("reset_rd_valid", a_rd_valid, 1'b0);
    chk("reset_rd_data", a_rd_data, 8'h00);
    chk("reset_err", a_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // 1: active read of every entry after reset
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 8'h00, 0, 0, 1, 0, 2'(i), 0);
      settle();
      chk("t1_rd_data", a_rd_data, 8'hA5);
      chk("t1_rd_valid", a_rd_valid, 1'b1);
    end
    idle();
    settle();
    chk("t1_rd_valid_drop", a_rd_valid, 1'b0);
    chk("t1_rd_data_hold", a_rd_data, 8'hA5);

    // 2: shadow write, reads of both copies, then commit
    drv(1, 1, 8'h3C, 1, 0, 0, 0, 0, 0);
    drv(0, 0, 8'h00, 0, 0, 1, 1, 1, 0);
    settle();
    chk("t2_shadow_rd", a_rd_data, 8'h3C);
    drv(0, 0, 8'h00, 0, 0, 1, 0, 1, 0);
    settle();
    chk("t2_active_rd", a_rd_data, 8'hA5);
    clr_cnt();
    drv(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    idle();
    repeat (8) @(posedge clk);
    #2;
    chk("t2_busy_cycles", cnt_busy, 4);
    chk("t2_done_a", cnt_done_a, 1);
    chk("t2_done_c", cnt_done_c, 1);
    chk("t2_register_out", a_reg, 32'hA5A53CA5);

    // 4: write with commit in the same cycle, second commit while copying
    clr_cnt();
    drv(1, 2, 8'h77, 1, 1, 0, 0, 0, 0);
    drv(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    idle();
    repeat (8) @(posedge clk);
    #2;
    chk("t4_done_a", cnt_done_a, 1);
    chk("t4_done_c", cnt_done_c, 1);
    drv(0, 0, 8'h00, 0, 0, 1, 0, 2, 0);
    settle();
    chk("t4_active_a", a_rd_data, 8'h77);
    chk("t4_active_c", c_rd_data, 8'h77);

    // zero strobe is a no-op
    drv(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 8'h00, 0, 0, 1, 1, 0, 0);
    settle();
    chk("strb0_shadow", a_rd_data, 8'hA5);

    // active read colliding with the copy of the same entry sees the old value
    drv(1, 0, 8'h5A, 1, 0, 0, 0, 0, 0);
    drv(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    drv(0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    settle();
    chk("copy_collide_rd", a_rd_data, 8'hA5);
    idle();
    repeat (6) @(posedge clk);
    drv(0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    settle();
    chk("copy_after_rd", a_rd_data, 8'h5A);
    chk("copy_register_out", a_reg, 32'hA5773C5A);

    // 5: out-of-range on the DEPTH=3 bank; same-cycle shadow write/read on DEPTH=4
    drv(1, 3, 8'hFF, 1, 0, 1, 1, 3, 0);
    settle();
    chk("t5_c_err", c_err, 1'b1);
    chk("t5_c_rd_zero", c_rd_data, 8'h00);
    chk("t5_c_rd_valid", c_rd_valid, 1'b1);
    chk("t5_c_reg_same", c_reg, 24'h773C5A);
    chk("t5_a_prewrite", a_rd_data, 8'hA5);
    chk("t5_a_err", a_err, 1'b0);
    drv(0, 0, 8'h00, 0, 0, 1, 1, 3, 1);
    settle();
    chk("t5_set_wins", c_err, 1'b1);
    chk("t5_a_postwrite", a_rd_data, 8'hFF);
    drv(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t5_cleared", c_err, 1'b0);
    idle();

    // 3: 16-bit bank byte strobes
    @(negedge clk);
    b_wr_valid = 1; b_wr_addr = 0; b_wr_data = 16'h1234; b_wr_strb = 2'b11;
    @(negedge clk);
    b_wr_data = 16'hABCD; b_wr_strb = 2'b10;
    @(negedge clk);
    b_wr_valid = 0; b_rd_en = 1; b_rd_sel = 1; b_rd_addr = 0;
    settle();
    chk("t3_shadow16", b_rd_data, 16'hAB34);
    chk("t3_rd_valid16", b_rd_valid, 1'b1);
    @(negedge clk);
    b_rd_sel = 0;
    settle();
    chk("t3_active16", b_rd_data, 16'h0000);
    @(negedge clk);
    b_rd_en = 0; b_commit = 1;
    @(negedge clk);
    b_commit = 0;
    repeat (6) @(posedge clk);
    #2;
    chk("t3_register_out16", b_reg, 64'h0000_0000_0000_AB34);

    // 6: reset in the middle of a copy
    drv(1, 0, 8'h11, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 8'h22, 1, 0, 0, 0, 0, 0);
    drv(1, 2, 8'h33, 1, 0, 0, 0, 0, 0);
    drv(1, 3, 8'h44, 1, 0, 0, 0, 0, 0);
    clr_cnt();
    drv(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    idle();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_reg_a", a_reg, 32'hA5A5A5A5);
    chk("t6_reg_c", c_reg, 24'hA5A5A5);
    chk("t6_done", a_commit_done, 1'b0);
    settle();
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("t6_ready", a_wr_ready, 1'b1);
    chk("t6_no_done_a", cnt_done_a, 0);
    chk("t6_no_done_c", cnt_done_c, 0);
    chk("t6_reg_after", a_reg, 32'hA5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
